// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings.
// master: the sequencer (drives the PLL areset and reset/status outputs).
// slave : the environment (PLL locked output, error-clear pulse).
interface pll_lock_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             locked;
   logic             clr_err;
   logic             pll_areset;
   logic             sys_rst;
   logic             ready;
   logic             fail;
   logic [CNT_W-1:0] lock_loss_cnt;

   modport master (
      input  locked, clr_err,
      output pll_areset, sys_rst, ready, fail, lock_loss_cnt
   );

   modport slave (
      output locked, clr_err,
      input  pll_areset, sys_rst, ready, fail, lock_loss_cnt
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for lock, qualifies that
// lock stays up, then releases the downstream system reset. Lock loss in RUN
// restarts the sequence; repeated lock timeouts end in a sticky FAIL state.
module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 1000,
   parameter int STABLE_CYCLES = 64,
   parameter int MAX_RETRY     = 3,
   parameter int CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 areset,
   pll_lock_sequencer_if.master bus
);

   localparam logic [2:0] S_RESET_PLL = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_FAIL      = 3'd4;

   // One shared cycle counter serves all timed states; size it for the longest.
   localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
   localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   logic [1:0]       sync_q, sync_d;
   logic             locked_s;
   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic [CNT_W-1:0] lock_loss_cnt_q, lock_loss_cnt_d;
   logic             pll_areset_q, pll_areset_d;
   logic             sys_rst_q, sys_rst_d;
   logic             ready_q, ready_d;
   logic             fail_q, fail_d;
   logic             loss;

   // Two-flop synchronizer shift for the asynchronous locked input.
   always_comb begin
      sync_d   = {sync_q[0], bus.locked};
      locked_s = sync_q[1];
   end

   // Sequencing FSM, retry bookkeeping and lock-loss counter.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q + CW'(1);
      retry_d         = retry_q;
      lock_loss_cnt_d = lock_loss_cnt_q;
      loss            = 1'b0;
      case (state_q)
         S_RESET_PLL: begin
            if (cnt_q == CW'(RST_CYCLES - 1)) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
               cnt_d = '0;
               if (retry_q == RW'(MAX_RETRY)) begin
                  state_d = S_FAIL;
               end else begin
                  state_d = S_RESET_PLL;
                  retry_d = retry_q + RW'(1);
               end
            end
         end
         S_STABLE: begin
            // Any dropout restarts the lock wait with a fresh timeout.
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            cnt_d   = '0;
            retry_d = '0;
            if (!locked_s) begin
               state_d = S_RESET_PLL;
               loss    = 1'b1;
            end
         end
         S_FAIL: begin
            cnt_d = '0;
            if (bus.clr_err) begin
               state_d = S_RESET_PLL;
               retry_d = '0;
            end
         end
         default: begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
         end
      endcase

      // A clear coinciding with a loss still records that loss.
      if (bus.clr_err) begin
         lock_loss_cnt_d = loss ? CNT_W'(1) : '0;
      end else if (loss && (lock_loss_cnt_q != '1)) begin
         lock_loss_cnt_d = lock_loss_cnt_q + CNT_W'(1);
      end
   end

   // Outputs decoded from the next state so they register together with it.
   always_comb begin
      pll_areset_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_rst_d    = (state_d != S_RUN);
      ready_d      = (state_d == S_RUN);
      fail_d       = (state_d == S_FAIL);
   end

   // State and output registers, asynchronously reset into RESET_PLL.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         sync_q          <= '0;
         state_q         <= S_RESET_PLL;
         cnt_q           <= '0;
         retry_q         <= '0;
         lock_loss_cnt_q <= '0;
         pll_areset_q    <= 1'b1;
         sys_rst_q       <= 1'b1;
         ready_q         <= 1'b0;
         fail_q          <= 1'b0;
      end else begin
         sync_q          <= sync_d;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         retry_q         <= retry_d;
         lock_loss_cnt_q <= lock_loss_cnt_d;
         pll_areset_q    <= pll_areset_d;
         sys_rst_q       <= sys_rst_d;
         ready_q         <= ready_d;
         fail_q          <= fail_d;
      end
   end

   assign bus.pll_areset    = pll_areset_q;
   assign bus.sys_rst       = sys_rst_q;
   assign bus.ready         = ready_q;
   assign bus.fail          = fail_q;
   assign bus.lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

   logic clk;
   logic areset;
   int   checks;
   int   failures;

   pll_lock_sequencer_if #(.CNT_W(8)) bus ();

   pll_lock_sequencer #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .MAX_RETRY    (2),
      .CNT_W        (8)
   ) dut (
      .clk   (clk),
      .areset(areset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for ready with a cycle budget; n is the number of edges taken.
   task automatic wait_ready(input int limit, output int n);
      n = 0;
      while (!bus.ready && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      areset      = 1'b1;
      bus.locked  = 1'b0;
      bus.clr_err = 1'b0;
      repeat (2) tick();
      checks++;
      if (bus.pll_areset !== 1'b1 || bus.sys_rst !== 1'b1 || bus.ready !== 1'b0 ||
          bus.fail !== 1'b0 || bus.lock_loss_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_state: got pa=%b sr=%b rdy=%b fail=%b llc=%0d expected 1 1 0 0 0",
                  bus.pll_areset, bus.sys_rst, bus.ready, bus.fail, bus.lock_loss_cnt);
      end
      areset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (bus.pll_areset !== (i < 4) || bus.sys_rst !== 1'b1 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_pll_len cycle %0d: got pa=%b sr=%b rdy=%b expected pa=%b sr=1 rdy=0",
                     i, bus.pll_areset, bus.sys_rst, bus.ready, (i < 4));
         end
      end
   endtask

   task automatic test_release();
      repeat (5) tick();
      bus.locked = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         checks++;
         if (bus.sys_rst !== (i < 11) || bus.ready !== (i >= 11)) begin
            failures++;
            $display("FAIL release cycle %0d: got sr=%b rdy=%b expected sr=%b rdy=%b",
                     i, bus.sys_rst, bus.ready, (i < 11), (i >= 11));
         end
      end
   endtask

   task automatic test_lock_loss_in_run();
      int n;
      bus.locked = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (bus.sys_rst !== (i >= 3) || bus.pll_areset !== (i >= 3) || bus.ready !== (i < 3)) begin
            failures++;
            $display("FAIL loss_react cycle %0d: got sr=%b pa=%b rdy=%b expected sr=%b pa=%b rdy=%b",
                     i, bus.sys_rst, bus.pll_areset, bus.ready, (i >= 3), (i >= 3), (i < 3));
         end
      end
      checks++;
      if (bus.lock_loss_cnt !== 8'd1) begin
         failures++;
         $display("FAIL loss_count: got %0d expected 1", bus.lock_loss_cnt);
      end
      bus.locked = 1'b1;
      wait_ready(40, n);
      checks++;
      if (n !== 13) begin
         failures++;
         $display("FAIL relock_latency: got %0d cycles expected 13", n);
      end
   endtask

   task automatic test_glitch();
      bus.locked = 1'b0;
      repeat (3) tick();
      bus.locked = 1'b1;
      repeat (5) tick();
      checks++;
      if (bus.sys_rst !== 1'b1 || bus.pll_areset !== 1'b0) begin
         failures++;
         $display("FAIL glitch_in_stable: got sr=%b pa=%b expected sr=1 pa=0", bus.sys_rst, bus.pll_areset);
      end
      repeat (5) tick();
      bus.locked = 1'b0;
      tick();
      bus.locked = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         checks++;
         if (bus.sys_rst !== (i < 11) || bus.pll_areset !== 1'b0) begin
            failures++;
            $display("FAIL glitch_requal cycle %0d: got sr=%b pa=%b expected sr=%b pa=0",
                     i, bus.sys_rst, bus.pll_areset, (i < 11));
         end
      end
      checks++;
      if (bus.lock_loss_cnt !== 8'd2) begin
         failures++;
         $display("FAIL glitch_loss_count: got %0d expected 2", bus.lock_loss_cnt);
      end
   endtask

   task automatic test_retry_fail();
      logic exp_pa;
      bus.locked = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus.lock_loss_cnt !== 8'd3) begin
         failures++;
         $display("FAIL retry_loss_count: got %0d expected 3", bus.lock_loss_cnt);
      end
      for (int t = 1; t <= 72; t++) begin
         tick();
         exp_pa = (t < 4) || (t >= 24 && t < 28) || (t >= 48 && t < 52) || (t >= 72);
         checks++;
         if (bus.pll_areset !== exp_pa || bus.fail !== (t >= 72) || bus.sys_rst !== 1'b1) begin
            failures++;
            $display("FAIL retry_seq t=%0d: got pa=%b fail=%b sr=%b expected pa=%b fail=%b sr=1",
                     t, bus.pll_areset, bus.fail, bus.sys_rst, exp_pa, (t >= 72));
         end
      end
      repeat (5) tick();
      checks++;
      if (bus.fail !== 1'b1 || bus.pll_areset !== 1'b1) begin
         failures++;
         $display("FAIL fail_hold: got fail=%b pa=%b expected 1 1", bus.fail, bus.pll_areset);
      end
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      checks++;
      if (bus.fail !== 1'b0 || bus.pll_areset !== 1'b1 || bus.lock_loss_cnt !== 8'd0) begin
         failures++;
         $display("FAIL clr_err_exit: got fail=%b pa=%b llc=%0d expected 0 1 0",
                  bus.fail, bus.pll_areset, bus.lock_loss_cnt);
      end
      repeat (4) tick();
      checks++;
      if (bus.pll_areset !== 1'b0) begin
         failures++;
         $display("FAIL clr_err_restart: got pa=%b expected 0", bus.pll_areset);
      end
      repeat (20) tick();
      checks++;
      if (bus.pll_areset !== 1'b1 || bus.fail !== 1'b0) begin
         failures++;
         $display("FAIL retry_cleared: got pa=%b fail=%b expected 1 0", bus.pll_areset, bus.fail);
      end
   endtask

   task automatic test_saturation();
      int n;
      int timeouts;
      timeouts   = 0;
      bus.locked = 1'b1;
      wait_ready(100, n);
      if (!bus.ready) timeouts++;
      for (int i = 0; i < 255; i++) begin
         bus.locked = 1'b0;
         repeat (3) tick();
         bus.locked = 1'b1;
         wait_ready(40, n);
         if (!bus.ready) timeouts++;
      end
      checks++;
      if (timeouts !== 0) begin
         failures++;
         $display("FAIL sat_relock: got %0d ready timeouts expected 0", timeouts);
      end
      checks++;
      if (bus.lock_loss_cnt !== 8'd255) begin
         failures++;
         $display("FAIL sat_reach: got %0d expected 255", bus.lock_loss_cnt);
      end
      bus.locked = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus.lock_loss_cnt !== 8'd255 || bus.sys_rst !== 1'b1) begin
         failures++;
         $display("FAIL sat_hold: got llc=%0d sr=%b expected 255 1", bus.lock_loss_cnt, bus.sys_rst);
      end
      bus.locked = 1'b1;
      wait_ready(40, n);
      checks++;
      if (bus.ready !== 1'b1) begin
         failures++;
         $display("FAIL sat_relock2: got rdy=%b expected 1", bus.ready);
      end
      bus.locked = 1'b0;
      repeat (2) tick();
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      checks++;
      if (bus.lock_loss_cnt !== 8'd1 || bus.ready !== 1'b0) begin
         failures++;
         $display("FAIL clr_with_loss: got llc=%0d rdy=%b expected 1 0", bus.lock_loss_cnt, bus.ready);
      end
   endtask

   task automatic test_areset_mid();
      int n;
      bus.locked = 1'b1;
      wait_ready(40, n);
      checks++;
      if (bus.ready !== 1'b1 || bus.lock_loss_cnt !== 8'd1) begin
         failures++;
         $display("FAIL pre_areset: got rdy=%b llc=%0d expected 1 1", bus.ready, bus.lock_loss_cnt);
      end
      areset = 1'b1;
      #1;
      checks++;
      if (bus.pll_areset !== 1'b1 || bus.sys_rst !== 1'b1 || bus.ready !== 1'b0 ||
          bus.lock_loss_cnt !== 8'd0) begin
         failures++;
         $display("FAIL areset_mid: got pa=%b sr=%b rdy=%b llc=%0d expected 1 1 0 0",
                  bus.pll_areset, bus.sys_rst, bus.ready, bus.lock_loss_cnt);
      end
      tick();
      areset = 1'b0;
      wait_ready(40, n);
      checks++;
      if (n !== 13) begin
         failures++;
         $display("FAIL areset_relock: got %0d cycles expected 13", n);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_release();
      test_lock_loss_in_run();
      test_glitch();
      test_retry_fail();
      test_saturation();
      test_areset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
